bus_master_cycle_gen: RTL
=========================

// Module: bus_master_cycle_gen
// PURPOSE
//  Initiator end of the multiplexed 8088-style local bus; complements the memory/IO responder FSM.
//  Turns a single-word host request into a T1-T2-T3-(Tw)-T4 bus cycle: ALE, rdb/wrb strobes,
//  multiplexed AD drive and IO/M select, with wait states from ready and a wait-timeout guard.
//  Sits between the CPU-model/test host and the shared bus beside the responder FSMs.
// PARAMETERS
//  ADDR_W    20  full address width; AD carries addr[7:0], a_hi carries addr[ADDR_W-1:8]
//  DATA_W    8   data width on AD (must be 8)
//  MAX_WAIT  15  max consecutive Tw states before forced T4 with timeout; range 1..255
// PORTS
//  clock     in   1         rising-edge clock
//  reset     in   1         synchronous, active-high
//  req       in   1         host request; accepted only when req_rdy=1
//  req_rdy   out  1         1 only in IDLE
//  req_we    in   1         1=write, 0=read; captured with req
//  req_iom   in   1         1=IO, 0=memory; captured with req
//  req_addr  in   ADDR_W    cycle address; captured with req
//  req_wdata in   DATA_W    write data; captured with req
//  ALE       out  1         address latch enable, high in T1 only
//  rdb       out  1         read strobe, active-low
//  wrb       out  1         write strobe, active-low
//  IOM       out  1         captured req_iom, valid T1..T4, 0 in IDLE
//  a_hi      out  ADDR_W-8  captured upper address, valid T1..T4, 0 in IDLE
//  ad_out    out  DATA_W    AD drive value
//  ad_oe     out  1         AD output enable (1=master drives AD)
//  ad_in     in   DATA_W    AD bus sampled value
//  ready     in   1         responder ready; sampled in T3/Tw
//  done      out  1         1-cycle pulse in T4
//  rdata     out  DATA_W    read data; held until next read completes
//  timeout   out  1         with done: cycle ended by MAX_WAIT expiry; else 0
// BEHAVIOUR
//  States (one-hot): IDLE, T1, T2, T3, TW, T4. Outputs are Moore, decoded from state + captured regs.
//  Reset: state=IDLE, capture regs=0, wait_cnt=0, rdata=0.
//   Outputs: ALE=0 rdb=1 wrb=1 IOM=0 a_hi=0 ad_out=0 ad_oe=0 done=0 timeout=0 req_rdy=1.
//  IDLE: req_rdy=1; req=1 at edge -> capture we/iom/addr/wdata, next T1. req ignored outside IDLE.
//  T1: ALE=1, ad_oe=1, ad_out=addr[7:0]; next T2 unconditionally.
//  T2: ALE=0.
//   Write: ad_oe=1, ad_out=wdata, wrb=0.
//   Read: ad_oe=0, rdb=0.
//   Next T3 unconditionally.
//  T3/TW: strobes and AD drive as in T2. ready is sampled at the edge leaving the state.
//   ready=1 -> T4; for reads, rdata<=ad_in on that same edge.
//   ready=0 in T3 -> TW, wait_cnt=1.
//   ready=0 in TW with wait_cnt<MAX_WAIT -> stay in TW, wait_cnt+1.
//   ready=0 in TW with wait_cnt==MAX_WAIT -> T4, timeout flag set; rdata unchanged.
//  T4: rdb=1, wrb=1, ad_oe=0, done=1, timeout=flag; next IDLE. Flag and wait_cnt clear in IDLE.
//  Latency: req accepted at edge k -> T1 during cycle k+1, done during cycle k+4 plus N wait states.
//   Minimum request spacing is 5 cycles (T4 -> IDLE -> accept).
//  Invariants:
//   - rdb and wrb are never low together.
//   - ad_oe=0 whenever rdb=0.
//   - ALE and the strobes are never active together.
//  Reset mid-cycle: at the next edge, all outputs return to reset values; no done pulse;
//   captured request discarded.
//  req held high continuously: one cycle per pass through IDLE; no request lost or duplicated.
// TESTING
//  1 reset; read addr=0x12345, iom=0, ready=1, ad_in=0xA5 in T3 -> ALE 1 cycle with ad_out=0x45,
//    a_hi=0x123; rdb low 2 cycles; done at k+4; rdata=0xA5
//  2 write addr=0x003F0, iom=1, wdata=0x5C, ready=1 -> IOM=1; ad_out=0xF0 in T1, 0x5C in T2/T3;
//    wrb low 2 cycles; rdb stays 1; done at k+4, timeout=0
//  3 read with ready=0 for 3 edges then 1, ad_in=0x3C -> 3 TW states; rdb low 5 cycles;
//    done at k+7; rdata=0x3C
//  4 ready held 0, MAX_WAIT=15 -> TW x15, then T4; done=1 with timeout=1; rdata keeps prior value;
//    next cycle normal
//  5 reset asserted during TW of a write -> next edge: wrb=1, ad_oe=0, IDLE; no done pulse;
//    new read then completes normally
//  6 req held high, alternating we -> back-to-back cycles every 5 cycles; req_rdy=1 only in IDLE;
//    strobe-exclusivity invariants checked every cycle

Source files
------------

// File: rtl/bus_master_cycle_gen_if.sv
// Host request and multiplexed 8088-style local bus signals seen by the cycle generator.
// The master modport is the generator; the slave modport is the host/bus side driving it.
interface bus_master_cycle_gen_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              req;
  logic              req_rdy;
  logic              req_we;
  logic              req_iom;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              ALE;
  logic              rdb;
  logic              wrb;
  logic              IOM;
  logic [ADDR_W-9:0] a_hi;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] ad_in;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              timeout;

  modport master (
    input  req, req_we, req_iom, req_addr, req_wdata, ad_in, ready,
    output req_rdy, ALE, rdb, wrb, IOM, a_hi, ad_out, ad_oe, done, rdata, timeout
  );

  modport slave (
    output req, req_we, req_iom, req_addr, req_wdata, ad_in, ready,
    input  req_rdy, ALE, rdb, wrb, IOM, a_hi, ad_out, ad_oe, done, rdata, timeout
  );
endinterface

// File: rtl/bus_master_cycle_gen.sv
// Bus initiator: one host word -> T1-T2-T3-(Tw)-T4 cycle; done 3 cycles after T1 plus waits.
// Backpressure: req_rdy only in IDLE; ready stretches T3 into Tw up to MAX_WAIT, then forced T4.
module bus_master_cycle_gen #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input logic                  clock,
  input logic                  reset,
  bus_master_cycle_gen_if.master bus
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_T1   = 6'b000010,
    S_T2   = 6'b000100,
    S_T3   = 6'b001000,
    S_TW   = 6'b010000,
    S_T4   = 6'b100000
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              iom_q, iom_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      iom_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      to_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      iom_q      <= iom_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      to_q       <= to_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    iom_d      = iom_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    to_d       = to_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        to_d       = 1'b0;
        wait_cnt_d = '0;
        if (bus.req) begin
          we_d    = bus.req_we;
          iom_d   = bus.req_iom;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3: begin
        if (bus.ready) begin
          state_d = S_T4;
          if (!we_q) rdata_d = bus.ad_in;
        end else begin
          state_d    = S_TW;
          wait_cnt_d = 8'd1;
        end
      end
      S_TW: begin
        if (bus.ready) begin
          state_d = S_T4;
          if (!we_q) rdata_d = bus.ad_in;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // Responder never answered: close the cycle, leave rdata untouched.
          state_d = S_T4;
          to_d    = 1'b1;
        end
      end
      S_T4:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_rdy = 1'b0;
    bus.ALE     = 1'b0;
    bus.rdb     = 1'b1;
    bus.wrb     = 1'b1;
    bus.IOM     = 1'b0;
    bus.a_hi    = '0;
    bus.ad_out  = '0;
    bus.ad_oe   = 1'b0;
    bus.done    = 1'b0;
    bus.timeout = 1'b0;
    bus.rdata   = rdata_q;

    unique case (state_q)
      S_IDLE: bus.req_rdy = 1'b1;
      S_T1: begin
        bus.ALE    = 1'b1;
        bus.ad_oe  = 1'b1;
        bus.ad_out = DATA_W'(addr_q[7:0]);
        bus.IOM    = iom_q;
        bus.a_hi   = addr_q[ADDR_W-1:8];
      end
      S_T2, S_T3, S_TW: begin
        bus.IOM  = iom_q;
        bus.a_hi = addr_q[ADDR_W-1:8];
        if (we_q) begin
          bus.ad_oe  = 1'b1;
          bus.ad_out = wdata_q;
          bus.wrb    = 1'b0;
        end else begin
          bus.rdb = 1'b0;
        end
      end
      S_T4: begin
        bus.IOM     = iom_q;
        bus.a_hi    = addr_q[ADDR_W-1:8];
        bus.done    = 1'b1;
        bus.timeout = to_q;
      end
      default: ;
    endcase
  end

endmodule
